// File: rtl/gate_unit_arbiter.sv
// gate_unit_arbiter
//   Round-robin arbiter/sequencer that time-shares one external combinational
//   gate unit among NREQ requesters. The winner's opcode/operands are
//   registered onto gu_op/gu_a/gu_b at grant. The arbiter then waits GU_LAT
//   cycles for gu_q to settle, captures it into result, and pulses ack to the
//   winner for one cycle.
//
// Ports
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   req[NREQ]       : per-requester request, held until its ack
//   op_flat         : 3-bit opcode per requester, requester i at [3i+2:3i]
//   a_flat, b_flat  : WIDTH-bit operands per requester, requester i at [W*i +: W]
//   gnt[NREQ]       : one-hot grant, high while the operation is in flight
//   ack[NREQ]       : one-hot single-cycle pulse; result is valid this cycle
//   result          : captured gate-unit result, held until the next capture
//   busy            : high whenever the sequencer is not idle
//   gu_op/gu_a/gu_b : registered inputs to the shared gate unit
//   gu_q            : output of the shared gate unit
module gate_unit_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned GU_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [3*NREQ-1:0]     op_flat,
  input  logic [WIDTH*NREQ-1:0] a_flat,
  input  logic [WIDTH*NREQ-1:0] b_flat,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      result,
  output logic                  busy,
  output logic [2:0]            gu_op,
  output logic [WIDTH-1:0]      gu_a,
  output logic [WIDTH-1:0]      gu_b,
  input  logic [WIDTH-1:0]      gu_q
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   cand;
  logic            pick_valid;
  logic [3:0]      cnt;

  logic [2:0]       op_arr [NREQ];
  logic [WIDTH-1:0] a_arr  [NREQ];
  logic [WIDTH-1:0] b_arr  [NREQ];

  // Unpack the flat per-requester buses.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      op_arr[i] = op_flat[3*i +: 3];
      a_arr[i]  = a_flat[WIDTH*i +: WIDTH];
      b_arr[i]  = b_flat[WIDTH*i +: WIDTH];
    end
  end

  // Round-robin pick: first requester at or above rr_ptr, wrapping at NREQ.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IW'((32'(rr_ptr) + k) % NREQ);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_valid) state_nxt = WAIT;
      WAIT:    if (cnt == '0)  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: grant/ack are decoded from the registered winner and state, so
  // they are one-hot or zero by construction and ack always implies gnt.
  always_comb begin
    gnt  = '0;
    ack  = '0;
    busy = (state != IDLE);
    if (state != IDLE) gnt[winner] = 1'b1;
    if (state == RESP) ack[winner] = 1'b1;
  end

  // Datapath: operand capture at grant, settle counter, result capture.
  // rr_ptr advances on the same edge that enters RESP; its value only matters
  // at the next IDLE sample, so this matches advancing during RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winner <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
      result <= '0;
      gu_op  <= '0;
      gu_a   <= '0;
      gu_b   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            winner <= pick_idx;
            gu_op  <= op_arr[pick_idx];
            gu_a   <= a_arr[pick_idx];
            gu_b   <= b_arr[pick_idx];
            cnt    <= 4'(GU_LAT - 1);
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            result <= gu_q;
            rr_ptr <= (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_unit_arbiter.sv
module tb_gate_unit_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT with GU_LAT=1
  logic [NREQ-1:0]       req, gnt, ack;
  logic [3*NREQ-1:0]     op_flat;
  logic [WIDTH*NREQ-1:0] a_flat, b_flat;
  logic [WIDTH-1:0]      result, gu_a, gu_b, gu_q;
  logic [2:0]            gu_op;
  logic                  busy;

  // DUT with GU_LAT=3
  logic [NREQ-1:0]       req3, gnt3, ack3;
  logic [3*NREQ-1:0]     op_flat3;
  logic [WIDTH*NREQ-1:0] a_flat3, b_flat3;
  logic [WIDTH-1:0]      result3, gu_a3, gu_b3, gu_q3;
  logic [2:0]            gu_op3;
  logic                  busy3;

  function automatic logic [WIDTH-1:0] gu_model(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~a;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return a ^ b;
      3'd6: return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  assign gu_q  = gu_model(gu_op, gu_a, gu_b);
  assign gu_q3 = gu_model(gu_op3, gu_a3, gu_b3);

  gate_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .GU_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_flat(op_flat),
    .a_flat(a_flat), .b_flat(b_flat), .gnt(gnt), .ack(ack),
    .result(result), .busy(busy), .gu_op(gu_op), .gu_a(gu_a),
    .gu_b(gu_b), .gu_q(gu_q)
  );

  gate_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .GU_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .op_flat(op_flat3),
    .a_flat(a_flat3), .b_flat(b_flat3), .gnt(gnt3), .ack(ack3),
    .result(result3), .busy(busy3), .gu_op(gu_op3), .gu_a(gu_a3),
    .gu_b(gu_b3), .gu_q(gu_q3)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Advance one cycle; inputs driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  // Wait (bounded) for an ack on the GU_LAT=1 DUT; returns winner index.
  task automatic wait_ack(output int idx);
    logic seen;
    seen = 1'b0;
    idx  = -1;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (ack != '0) seen = 1'b1;
    end
    chk("ack_seen", 32'(seen), 32'd1);
    if (seen) begin
      idx = onehot_idx(ack);
      chk("ack_onehot", $countones(ack), 32'd1);
      chk("gnt_eq_ack", 32'(gnt), 32'(ack));
    end
  endtask

  int w;
  int exp_order [5] = '{0, 1, 2, 3, 0};
  logic [7:0] exp_res [4] = '{8'h0C, 8'h3F, 8'hC3, 8'hF3};

  initial begin
    req = '0; op_flat = '0; a_flat = '0; b_flat = '0;
    req3 = '0; op_flat3 = '0; a_flat3 = '0; b_flat3 = '0;

    // Reset then idle
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_gu_a", 32'(gu_a), 32'd0);
    end
    rst_n = 1'b1;
    step();
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // Single op: requester 0, NOR F0,0C -> 03
    op_flat[2:0] = 3'd4; a_flat[7:0] = 8'hF0; b_flat[7:0] = 8'h0C;
    req = 4'b0001;            // cycle T
    step();                   // T+1
    chk("single_gnt", 32'(gnt), 32'h1);
    chk("single_noack", 32'(ack), 32'h0);
    chk("single_gu_op", 32'(gu_op), 32'd4);
    step();                   // T+2
    chk("single_ack", 32'(ack), 32'h1);
    chk("single_gnt2", 32'(gnt), 32'h1);
    chk("single_result", 32'(result), 32'h03);
    req = '0;
    step();                   // T+3
    chk("single_idle", 32'(busy), 32'd0);
    chk("single_hold", 32'(result), 32'h03);

    // Contention: reset so rr_ptr=0, then all four request continuously
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      op_flat[3*i +: 3]     = 3'(i);
      a_flat[WIDTH*i +: 8]  = 8'h3C;
      b_flat[WIDTH*i +: 8]  = 8'h0F;
    end
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_ack(w);
      chk("rr_order", 32'(w), 32'(exp_order[n]));
      if (w >= 0) begin
        chk("rr_result", 32'(result), 32'(exp_res[w]));
        req[w] = 1'b0;
      end
      step();                 // IDLE cycle, requester re-raises
      if (n < 4 && w >= 0) req[w] = 1'b1;
    end
    req = '0;
    step();

    // Pointer wrap: serve 2 so rr_ptr=3, then 1001 -> 3 then 0
    req = 4'b0100;
    wait_ack(w);
    chk("wrap_pre", 32'(w), 32'd2);
    req = '0;
    step();
    req = 4'b1001;
    wait_ack(w);
    chk("wrap_first", 32'(w), 32'd3);
    req[3] = 1'b0;
    wait_ack(w);
    chk("wrap_second", 32'(w), 32'd0);
    req = '0;
    step();

    // Latency/operand stability on GU_LAT=3: requester 1, XOR AA,FF
    op_flat3[5:3] = 3'd5; a_flat3[15:8] = 8'hAA; b_flat3[15:8] = 8'hFF;
    req3 = 4'b0010;           // T
    step();                   // T+1
    chk("lat_gnt", 32'(gnt3), 32'h2);
    chk("lat_gu_a", 32'(gu_a3), 32'hAA);
    a_flat3[15:8] = 8'h11;
    for (int c = 2; c <= 3; c++) begin
      step();                 // T+2, T+3
      chk("lat_noack", 32'(ack3), 32'h0);
      chk("lat_gu_a_hold", 32'(gu_a3), 32'hAA);
      chk("lat_gnt_hold", 32'(gnt3), 32'h2);
    end
    step();                   // T+4
    chk("lat_ack", 32'(ack3), 32'h2);
    chk("lat_result", 32'(result3), 32'h55);
    req3 = '0;
    step();
    chk("lat_idle", 32'(busy3), 32'd0);

    // Reset mid-op: requester 2 on GU_LAT=3, reset during WAIT
    op_flat3[8:6] = 3'd0; a_flat3[23:16] = 8'hFF; b_flat3[23:16] = 8'h81;
    req3 = 4'b0100;
    step();                   // T+1 granted
    chk("mid_gnt", 32'(gnt3), 32'h4);
    step();                   // T+2, in WAIT
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt3), 32'h0);
    chk("mid_rst_ack", 32'(ack3), 32'h0);
    chk("mid_rst_busy", 32'(busy3), 32'd0);
    chk("mid_rst_result", 32'(result3), 32'h0);
    req3 = '0;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("mid_no_ack", 32'(ack3), 32'h0);
    end
    // rr_ptr was 2 before reset; after reset 1 must win over 3
    a_flat3[15:8] = 8'h0F; b_flat3[15:8] = 8'h0F; op_flat3[5:3] = 3'd6;
    a_flat3[31:24] = 8'h00; op_flat3[11:9] = 3'd0;
    req3 = 4'b1010;
    step();
    chk("post_gnt", 32'(gnt3), 32'h2);
    for (int c = 0; c < 2; c++) step();
    step();
    chk("post_ack", 32'(ack3), 32'h2);
    chk("post_result", 32'(result3), 32'hFF);
    req3 = '0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
